engine_read_write_index_scheduler: RTL and testbench

Sequencer that sits between the read/write engine's configure FIFO and its memory-request path. It pops one CSR index configuration at a time and walks the index range [index_start, index_end) with a programmable stride. For each index it issues one request beat carrying the index, the byte address and the meta, and it pulses done when the range is exhausted. Throughput is one beat per cycle under ready/valid backpressure.

---
 rtl/engine_read_write_index_scheduler_pkg.sv | 43 ++++
 rtl/engine_read_write_index_scheduler_step.sv | 28 ++
 rtl/engine_read_write_index_scheduler.sv | 187 ++++++++++++++++++
 tb/tb_engine_read_write_index_scheduler.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/engine_read_write_index_scheduler_pkg.sv
// Shared types for the read/write engine index scheduler: FSM states,
// request beat layout, CSR configuration layout and the address helper.
package engine_read_write_index_scheduler_pkg;

   localparam int PKG_INDEX_W = 32;
   localparam int PKG_ADDR_W  = 64;
   localparam int PKG_META_W  = 64;
   localparam int PKG_GRAN_W  = 3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } index_scheduler_state_e;

   typedef struct packed {
      logic [PKG_INDEX_W-1:0] index;
      logic [PKG_ADDR_W-1:0]  address;
      logic [PKG_META_W-1:0]  meta;
      logic                   last;
   } index_scheduler_request_t;

   typedef struct packed {
      logic [PKG_INDEX_W-1:0] index_start;
      logic [PKG_INDEX_W-1:0] index_end;
      logic [PKG_INDEX_W-1:0] stride;
      logic [PKG_GRAN_W-1:0]  granularity;
      logic [PKG_ADDR_W-1:0]  array_pointer;
      logic [PKG_META_W-1:0]  meta;
   } csr_index_configuration_t;

   // Byte address of an element; the sum wraps modulo 2^ADDR_W.
   function automatic logic [PKG_ADDR_W-1:0] index_address(
      input logic [PKG_ADDR_W-1:0]  pointer,
      input logic [PKG_INDEX_W-1:0] index,
      input logic [PKG_GRAN_W-1:0]  granularity
   );
      logic [PKG_ADDR_W-1:0] offset;
      offset = PKG_ADDR_W'(index) << granularity;
      return pointer + offset;
   endfunction

endpackage

// File: rtl/engine_read_write_index_scheduler_step.sv
// Combinational index stepper: successor index and whether that successor
// falls outside the range (carry out of the index width or >= end).
module engine_read_write_index_step #(
   parameter int INDEX_W = 32
) (
   input  logic [INDEX_W-1:0] index,
   input  logic [INDEX_W-1:0] stride,
   input  logic [INDEX_W-1:0] index_end,
   output logic [INDEX_W-1:0] next_index,
   output logic               range_end
);

   logic [INDEX_W-1:0] stride_eff_s;
   logic [INDEX_W:0]   sum_s;

   // Zero stride behaves as one; the extra sum bit catches index wrap.
   always_comb begin
      if (stride == {INDEX_W{1'b0}}) begin
         stride_eff_s = INDEX_W'(1);
      end else begin
         stride_eff_s = stride;
      end
      sum_s      = {1'b0, index} + {1'b0, stride_eff_s};
      next_index = sum_s[INDEX_W-1:0];
      range_end  = sum_s[INDEX_W] | (sum_s[INDEX_W-1:0] >= index_end);
   end

endmodule

// File: rtl/engine_read_write_index_scheduler.sv
// Pops one index configuration at a time and walks [start, end) with a
// stride, emitting one registered request beat per index, then pulses done.
module engine_read_write_index_scheduler
   import engine_read_write_index_scheduler_pkg::*;
#(
   parameter int INDEX_W = PKG_INDEX_W,
   parameter int ADDR_W  = PKG_ADDR_W,
   parameter int META_W  = PKG_META_W,
   parameter int GRAN_W  = PKG_GRAN_W
) (
   input  logic               ap_clk,
   input  logic               ap_rst_n,
   input  logic               cfg_valid,
   output logic               cfg_ready,
   input  logic [INDEX_W-1:0] cfg_index_start,
   input  logic [INDEX_W-1:0] cfg_index_end,
   input  logic [INDEX_W-1:0] cfg_stride,
   input  logic [GRAN_W-1:0]  cfg_granularity,
   input  logic [ADDR_W-1:0]  cfg_array_pointer,
   input  logic [META_W-1:0]  cfg_meta,
   input  logic               pause,
   output logic               req_valid,
   input  logic               req_ready,
   output logic [INDEX_W-1:0] req_index,
   output logic [ADDR_W-1:0]  req_address,
   output logic [META_W-1:0]  req_meta,
   output logic               req_last,
   output logic               busy,
   output logic               done,
   output logic [INDEX_W-1:0] beat_count
);

   index_scheduler_state_e   state_r;
   index_scheduler_state_e   state_nxt_s;
   index_scheduler_request_t req_r;

   logic               req_valid_r;
   logic               cfg_ready_r;
   logic               done_r;
   logic               busy_r;
   logic [INDEX_W-1:0] beat_count_r;
   logic [INDEX_W-1:0] upcoming_r;
   logic [INDEX_W-1:0] end_r;
   logic [INDEX_W-1:0] stride_r;
   logic [GRAN_W-1:0]  gran_r;
   logic [ADDR_W-1:0]  ptr_r;

   logic               accept_s;
   logic               handshake_s;
   logic               load_s;
   logic [INDEX_W-1:0] step_index_s;
   logic [INDEX_W-1:0] step_stride_s;
   logic [INDEX_W-1:0] step_end_s;
   logic [INDEX_W-1:0] step_next_s;
   logic               step_range_end_s;
   logic [GRAN_W-1:0]  load_gran_s;
   logic [ADDR_W-1:0]  load_ptr_s;

   // In IDLE the first beat is built straight from the cfg inputs so it can
   // be presented the cycle after accept; afterwards from latched state.
   always_comb begin
      accept_s    = (state_r == ST_IDLE) && cfg_valid && cfg_ready_r;
      handshake_s = req_valid_r && req_ready;
      if (state_r == ST_IDLE) begin
         step_index_s  = cfg_index_start;
         step_stride_s = cfg_stride;
         step_end_s    = cfg_index_end;
         load_gran_s   = cfg_granularity;
         load_ptr_s    = cfg_array_pointer;
      end else begin
         step_index_s  = upcoming_r;
         step_stride_s = stride_r;
         step_end_s    = end_r;
         load_gran_s   = gran_r;
         load_ptr_s    = ptr_r;
      end
   end

   engine_read_write_index_step #(
      .INDEX_W (INDEX_W)
   ) u_step (
      .index      (step_index_s),
      .stride     (step_stride_s),
      .index_end  (step_end_s),
      .next_index (step_next_s),
      .range_end  (step_range_end_s)
   );

   // Next-state and beat-load decision.
   always_comb begin
      state_nxt_s = state_r;
      load_s      = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               if (cfg_index_start >= cfg_index_end) begin
                  state_nxt_s = ST_DONE;
               end else begin
                  state_nxt_s = ST_RUN;
                  load_s      = !pause;
               end
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (handshake_s && req_r.last) begin
               state_nxt_s = ST_DONE;
            end else if (handshake_s || !req_valid_r) begin
               load_s = !pause;
            end else begin
               load_s = 1'b0;
            end
         end
         ST_DONE: begin
            state_nxt_s = ST_IDLE;
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // FSM state register.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Configuration latch, request beat, status and counter registers.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         cfg_ready_r  <= 1'b0;
         done_r       <= 1'b0;
         busy_r       <= 1'b0;
         req_valid_r  <= 1'b0;
         req_r        <= '0;
         beat_count_r <= {INDEX_W{1'b0}};
         upcoming_r   <= {INDEX_W{1'b0}};
         end_r        <= {INDEX_W{1'b0}};
         stride_r     <= {INDEX_W{1'b0}};
         gran_r       <= {GRAN_W{1'b0}};
         ptr_r        <= {ADDR_W{1'b0}};
      end else begin
         cfg_ready_r <= (state_r == ST_IDLE) && !accept_s;
         done_r      <= (state_r == ST_DONE);
         busy_r      <= (state_nxt_s != ST_IDLE);

         if (accept_s) begin
            end_r        <= cfg_index_end;
            stride_r     <= cfg_stride;
            gran_r       <= cfg_granularity;
            ptr_r        <= cfg_array_pointer;
            req_r.meta   <= cfg_meta;
            upcoming_r   <= cfg_index_start;
            beat_count_r <= {INDEX_W{1'b0}};
         end else if (handshake_s) begin
            beat_count_r <= beat_count_r + INDEX_W'(1);
         end

         // A beat is only replaced after its handshake, so req_* hold under stall.
         if (load_s) begin
            req_valid_r   <= 1'b1;
            req_r.index   <= step_index_s;
            req_r.address <= index_address(load_ptr_s, step_index_s, load_gran_s);
            req_r.last    <= step_range_end_s;
            upcoming_r    <= step_next_s;
         end else if (handshake_s) begin
            req_valid_r <= 1'b0;
         end
      end
   end

   assign cfg_ready   = cfg_ready_r;
   assign req_valid   = req_valid_r;
   assign req_index   = req_r.index;
   assign req_address = req_r.address;
   assign req_meta    = req_r.meta;
   assign req_last    = req_r.last;
   assign busy        = busy_r;
   assign done        = done_r;
   assign beat_count  = beat_count_r;

endmodule

// File: tb/tb_engine_read_write_index_scheduler.sv
// Scoreboard bench for the index scheduler: directed configs push expected
// beats/done counts; a negedge monitor pops and compares on every handshake.
module tb_engine_read_write_index_scheduler;

   logic        ap_clk = 1'b0;
   logic        ap_rst_n;
   logic        cfg_valid;
   logic        cfg_ready;
   logic [31:0] cfg_index_start;
   logic [31:0] cfg_index_end;
   logic [31:0] cfg_stride;
   logic [2:0]  cfg_granularity;
   logic [63:0] cfg_array_pointer;
   logic [63:0] cfg_meta;
   logic        pause;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_index;
   logic [63:0] req_address;
   logic [63:0] req_meta;
   logic        req_last;
   logic        busy;
   logic        done;
   logic [31:0] beat_count;

   typedef struct {
      logic [31:0] index;
      logic [63:0] address;
      logic [63:0] meta;
      logic        last;
   } beat_t;

   beat_t       exp_q[$];
   int          done_q[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   int          cyc = 0;
   int          hs_cnt = 0;
   int          first_hs_cyc = 0;
   int          last_hs_cyc = 0;
   int          acc_cyc = 0;
   int          done_cyc = 0;
   logic [63:0] cur_meta = 64'h0;

   engine_read_write_index_scheduler dut (
      .ap_clk            (ap_clk),
      .ap_rst_n          (ap_rst_n),
      .cfg_valid         (cfg_valid),
      .cfg_ready         (cfg_ready),
      .cfg_index_start   (cfg_index_start),
      .cfg_index_end     (cfg_index_end),
      .cfg_stride        (cfg_stride),
      .cfg_granularity   (cfg_granularity),
      .cfg_array_pointer (cfg_array_pointer),
      .cfg_meta          (cfg_meta),
      .pause             (pause),
      .req_valid         (req_valid),
      .req_ready         (req_ready),
      .req_index         (req_index),
      .req_address       (req_address),
      .req_meta          (req_meta),
      .req_last          (req_last),
      .busy              (busy),
      .done              (done),
      .beat_count        (beat_count)
   );

   always #5 ap_clk = ~ap_clk;

   initial forever begin
      @(posedge ap_clk);
      cyc++;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic note_fail(input string name);
      n_cmp++;
      n_bad++;
      $display("FAIL %s (cycle %0d)", name, cyc);
   endtask

   task automatic push_beat(input logic [31:0] idx, input logic [63:0] addr, input logic last);
      beat_t b;
      b.index   = idx;
      b.address = addr;
      b.meta    = cur_meta;
      b.last    = last;
      exp_q.push_back(b);
   endtask

   // Monitor: every accepted beat and every done pulse must match the queues.
   initial forever begin
      @(negedge ap_clk);
      if (ap_rst_n === 1'b1) begin
         if (req_valid && req_ready) begin
            if (exp_q.size() == 0) begin
               note_fail("unexpected_beat");
            end else begin
               beat_t e;
               e = exp_q.pop_front();
               check("beat_index", req_index, e.index);
               check("beat_address", req_address, e.address);
               check("beat_meta", req_meta, e.meta);
               check("beat_last", req_last, e.last);
            end
            if (hs_cnt == 0) first_hs_cyc = cyc;
            last_hs_cyc = cyc;
            hs_cnt++;
         end
         if (done) begin
            if (done_q.size() == 0) begin
               note_fail("unexpected_done");
            end else begin
               check("done_beat_count", beat_count, done_q.pop_front());
               check("done_not_busy", busy, 1'b0);
            end
         end
      end
   end

   // Called at posedge+1; returns at posedge+1 just after the accept edge.
   task automatic issue(input logic [31:0] s, input logic [31:0] e, input logic [31:0] st,
                        input logic [2:0] g, input logic [63:0] p);
      int n = 0;
      while (!cfg_ready && n < 20) begin
         @(posedge ap_clk); #1;
         n++;
      end
      if (!cfg_ready) note_fail("cfg_ready_timeout");
      cfg_index_start   = s;
      cfg_index_end     = e;
      cfg_stride        = st;
      cfg_granularity   = g;
      cfg_array_pointer = p;
      cfg_meta          = cur_meta;
      cfg_valid         = 1'b1;
      acc_cyc           = cyc;
      @(posedge ap_clk); #1;
      cfg_valid = 1'b0;
   endtask

   task automatic wait_done();
      int  n = 0;
      bit  seen = 1'b0;
      while (!seen && n < 300) begin
         @(posedge ap_clk); #1;
         n++;
         if (done) begin
            seen     = 1'b1;
            done_cyc = cyc;
         end
      end
      if (!seen) note_fail("done_timeout");
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog_timeout");
      $fatal(1, "bench watchdog expired");
   end

   initial begin
      ap_rst_n = 1'b0; cfg_valid = 1'b0; pause = 1'b0; req_ready = 1'b1;
      cfg_index_start = 32'h0; cfg_index_end = 32'h0; cfg_stride = 32'h0;
      cfg_granularity = 3'h0; cfg_array_pointer = 64'h0; cfg_meta = 64'h0;
      #1;
      check("rst_cfg_ready", cfg_ready, 1'b0);
      check("rst_req_valid", req_valid, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_beat_count", beat_count, 32'h0);
      check("rst_req_address", req_address, 64'h0);
      repeat (2) @(posedge ap_clk);
      #1 ap_rst_n = 1'b1;
      check("rel_cfg_ready_low", cfg_ready, 1'b0);
      @(posedge ap_clk); #1;
      check("rel_cfg_ready_high", cfg_ready, 1'b1);

      // Basic walk, gran 2.
      cur_meta = 64'hA1A1_0000_0000_0001;
      push_beat(32'd0, 64'h1000, 1'b0);
      push_beat(32'd1, 64'h1004, 1'b0);
      push_beat(32'd2, 64'h1008, 1'b0);
      push_beat(32'd3, 64'h100C, 1'b1);
      done_q.push_back(4);
      hs_cnt = 0;
      issue(32'd0, 32'd4, 32'd1, 3'd2, 64'h1000);
      check("t1_first_valid", req_valid, 1'b1);
      check("t1_busy", busy, 1'b1);
      wait_done();
      check("t1_back_to_back", 64'(last_hs_cyc - first_hs_cyc), 64'd3);
      check("t1_beat_count", beat_count, 32'd4);
      check("t1_cfg_ready_during_done", cfg_ready, 1'b0);
      @(posedge ap_clk); #1;
      check("t1_cfg_ready_after_done", cfg_ready, 1'b1);

      // Stride 3 and stride 0.
      cur_meta = 64'hB2B2_0000_0000_0002;
      push_beat(32'd2, 64'h102, 1'b0);
      push_beat(32'd5, 64'h105, 1'b0);
      push_beat(32'd8, 64'h108, 1'b1);
      done_q.push_back(3);
      issue(32'd2, 32'd11, 32'd3, 3'd0, 64'h100);
      wait_done();
      cur_meta = 64'hC3C3_0000_0000_0003;
      push_beat(32'd7, 64'h1E, 1'b0);
      push_beat(32'd8, 64'h20, 1'b1);
      done_q.push_back(2);
      issue(32'd7, 32'd9, 32'd0, 3'd1, 64'h10);
      wait_done();

      // Empty ranges.
      cur_meta = 64'hD4D4_0000_0000_0004;
      done_q.push_back(0);
      issue(32'd5, 32'd5, 32'd1, 3'd0, 64'h0);
      wait_done();
      check("empty_eq_done_latency", 64'(done_cyc - acc_cyc), 64'd2);
      @(posedge ap_clk); #1;
      check("empty_eq_cfg_ready", cfg_ready, 1'b1);
      done_q.push_back(0);
      issue(32'd9, 32'd3, 32'd1, 3'd0, 64'h0);
      wait_done();
      check("empty_gt_done_latency", 64'(done_cyc - acc_cyc), 64'd2);
      @(posedge ap_clk); #1;
      check("empty_gt_cfg_ready", cfg_ready, 1'b1);

      // Backpressure on index 1 for three cycles.
      cur_meta = 64'hE5E5_0000_0000_0005;
      push_beat(32'd0, 64'h2000, 1'b0);
      push_beat(32'd1, 64'h2008, 1'b0);
      push_beat(32'd2, 64'h2010, 1'b1);
      done_q.push_back(3);
      issue(32'd0, 32'd3, 32'd1, 3'd3, 64'h2000);
      @(posedge ap_clk); #1;
      req_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         check("bp_valid", req_valid, 1'b1);
         check("bp_index", req_index, 32'd1);
         check("bp_address", req_address, 64'h2008);
         check("bp_last", req_last, 1'b0);
         @(posedge ap_clk); #1;
      end
      req_ready = 1'b1;
      wait_done();

      // Pause rising together with a handshake.
      cur_meta = 64'hF6F6_0000_0000_0006;
      push_beat(32'd0, 64'h300, 1'b0);
      push_beat(32'd1, 64'h301, 1'b0);
      push_beat(32'd2, 64'h302, 1'b1);
      done_q.push_back(3);
      req_ready = 1'b0;
      issue(32'd0, 32'd3, 32'd1, 3'd0, 64'h300);
      check("pause_pre_valid", req_valid, 1'b1);
      pause = 1'b1; req_ready = 1'b1;
      @(posedge ap_clk); #1;
      check("pause_withheld_1", req_valid, 1'b0);
      check("pause_busy", busy, 1'b1);
      @(posedge ap_clk); #1;
      check("pause_withheld_2", req_valid, 1'b0);
      pause = 1'b0;
      @(posedge ap_clk); #1;
      check("pause_resume_valid", req_valid, 1'b1);
      check("pause_resume_index", req_index, 32'd1);
      wait_done();

      // Index carry at the top of the range.
      cur_meta = 64'h0707_0000_0000_0007;
      push_beat(32'hFFFF_FFFE, 64'hF000_000F_FFFF_FFE0, 1'b1);
      done_q.push_back(1);
      issue(32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd4, 3'd4, 64'hF000_0000_0000_0000);
      wait_done();

      // Reset mid-range after two beats.
      cur_meta = 64'h0808_0000_0000_0008;
      push_beat(32'd0, 64'h500, 1'b0);
      push_beat(32'd1, 64'h501, 1'b0);
      issue(32'd0, 32'd10, 32'd1, 3'd0, 64'h500);
      @(posedge ap_clk); #1;
      @(posedge ap_clk); #1;
      check("mid_index_before_rst", req_index, 32'd2);
      ap_rst_n = 1'b0;
      #1;
      check("mid_rst_req_valid", req_valid, 1'b0);
      check("mid_rst_busy", busy, 1'b0);
      check("mid_rst_beat_count", beat_count, 32'd0);
      @(posedge ap_clk); #1;
      ap_rst_n = 1'b1;
      @(posedge ap_clk); #1;
      check("mid_rel_cfg_ready", cfg_ready, 1'b1);
      check("mid_rel_busy", busy, 1'b0);
      cur_meta = 64'h0909_0000_0000_0009;
      push_beat(32'd3, 64'h603, 1'b0);
      push_beat(32'd4, 64'h604, 1'b1);
      done_q.push_back(2);
      issue(32'd3, 32'd5, 32'd1, 3'd0, 64'h600);
      wait_done();

      repeat (3) @(posedge ap_clk);
      #1;
      check("beats_left", 64'(exp_q.size()), 64'd0);
      check("dones_left", 64'(done_q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
